// File: rtl/mem_stage_if.sv
// Bundle of the execute-side, data-memory-side and writeback signals of the
// memory-access stage. The stage uses the slave view; the environment that
// drives it (execute, memory model, regfile) uses the master view.
//
// Handshake rules:
//   - A transfer on ex_valid/ex_ready or on mem_req_valid/mem_req_ready
//     happens on a rising edge where both signals are 1.
//   - A valid side that is waiting holds its payload stable until the
//     transfer happens.
//   - mem_rsp_valid has no ready: the stage samples it only in WAIT.
//   - wb_valid is a one-cycle pulse.
interface mem_stage_if #(
    parameter int DW = 16
);
    // execute -> stage
    logic          ex_valid;
    logic          ex_ready;
    logic          ex_ldst;
    logic [4:0]    ex_opcode;
    logic [DW-1:0] ex_result;
    logic [DW-1:0] ex_store_data;
    logic [2:0]    ex_rd;
    logic          ex_wr;
    // stage <-> data memory
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [DW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_rsp_valid;
    logic [DW-1:0] mem_rsp_data;
    // stage -> regfile write port
    logic          wb_valid;
    logic          wb_wr;
    logic [2:0]    wb_rd;
    logic [DW-1:0] wb_data;
    logic          mem_excep;

    modport slave (
        input  ex_valid, ex_ldst, ex_opcode, ex_result, ex_store_data, ex_rd, ex_wr,
        output ex_ready,
        output mem_req_valid, mem_addr, mem_wdata, mem_we,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output wb_valid, wb_wr, wb_rd, wb_data, mem_excep
    );

    modport master (
        output ex_valid, ex_ldst, ex_opcode, ex_result, ex_store_data, ex_rd, ex_wr,
        input  ex_ready,
        input  mem_req_valid, mem_addr, mem_wdata, mem_we,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  wb_valid, wb_wr, wb_rd, wb_data, mem_excep
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage. Non-memory instructions pass straight to a registered
// writeback record one cycle after acceptance. Loads/stores go through a
// single-outstanding request/response exchange with data memory
// (IDLE -> REQ -> WAIT -> IDLE) with a response timeout counted in WAIT.
// Execute is stalled (ex_ready=0) whenever the FSM is not in IDLE.
module mem_stage #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    mem_stage_if.slave bus,
    output logic [1:0] o_dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [4:0] OP_LD  = 5'b10001;
    localparam logic [4:0] OP_ST  = 5'b10000;
    localparam logic [4:0] OP_STU = 5'b10011;

    // The counter value seen in the last WAIT cycle before giving up; the
    // timeout fires after exactly TIMEOUT WAIT cycles with no response.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]    r_state;
    logic [7:0]    r_cnt;
    logic [4:0]    r_opcode;
    logic [DW-1:0] r_addr;
    logic [DW-1:0] r_sdata;
    logic [2:0]    r_rd;
    logic          r_wb_valid;
    logic          r_wb_wr;
    logic [2:0]    r_wb_rd;
    logic [DW-1:0] r_wb_data;
    logic          r_excep;

    logic w_idle;
    logic w_in_req;
    logic w_accept;
    logic w_is_mem;
    logic w_timeout;

    assign w_idle    = (r_state == S_IDLE);
    assign w_in_req  = (r_state == S_REQ);
    assign w_accept  = bus.ex_valid && w_idle;
    assign w_is_mem  = bus.ex_ldst &&
                       ((bus.ex_opcode == OP_LD) ||
                        (bus.ex_opcode == OP_ST) ||
                        (bus.ex_opcode == OP_STU));
    assign w_timeout = (r_cnt == TO_LAST);

    // ex_ready depends on state only, so there is no combinational path from
    // the memory interface back into execute.
    assign bus.ex_ready = w_idle;

    // Request fields come from registers latched at acceptance, so they are
    // stable for the whole REQ phase; they read as zero outside REQ.
    assign bus.mem_req_valid = w_in_req;
    assign bus.mem_addr      = w_in_req ? r_addr  : '0;
    assign bus.mem_wdata     = w_in_req ? r_sdata : '0;
    assign bus.mem_we        = w_in_req && (r_opcode != OP_LD);

    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_wr     = r_wb_wr;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;
    assign bus.mem_excep = r_excep;

    assign o_dbg_state = r_state;

    // FSM: IDLE accepts, REQ waits for request handshake, WAIT waits for the
    // response or the timeout. Responses outside WAIT are ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mem) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.mem_req_ready) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_rsp_valid || w_timeout) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Timeout counter: cleared when the request is accepted, counts WAIT
    // cycles that pass without a response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_in_req && bus.mem_req_ready) begin
            r_cnt <= '0;
        end else if ((r_state == S_WAIT) && !bus.mem_rsp_valid && !w_timeout) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Instruction fields latched on acceptance and held until the next one.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_opcode <= '0;
            r_addr   <= '0;
            r_sdata  <= '0;
            r_rd     <= '0;
        end else if (w_accept) begin
            r_opcode <= bus.ex_opcode;
            r_addr   <= bus.ex_result;
            r_sdata  <= bus.ex_store_data;
            r_rd     <= bus.ex_rd;
        end
    end

    // Writeback record: valid/wr/excep are single-cycle pulses, rd/data hold
    // their last value between records. The response is checked before the
    // timeout so a response in the final WAIT cycle still completes normally.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wb_valid <= 1'b0;
            r_wb_wr    <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_data  <= '0;
            r_excep    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_wr    <= 1'b0;
            r_excep    <= 1'b0;
            if (w_accept && !w_is_mem) begin
                r_wb_valid <= 1'b1;
                r_wb_wr    <= bus.ex_wr;
                r_wb_rd    <= bus.ex_rd;
                r_wb_data  <= bus.ex_result;
            end else if ((r_state == S_WAIT) && bus.mem_rsp_valid) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_rd;
                case (r_opcode)
                    OP_LD: begin
                        r_wb_wr   <= 1'b1;
                        r_wb_data <= bus.mem_rsp_data;
                    end
                    OP_STU: begin
                        r_wb_wr   <= 1'b1;
                        r_wb_data <= r_addr;
                    end
                    default: begin
                        r_wb_wr   <= 1'b0;
                        r_wb_data <= '0;
                    end
                endcase
            end else if ((r_state == S_WAIT) && w_timeout) begin
                r_wb_valid <= 1'b1;
                r_wb_wr    <= 1'b0;
                r_wb_rd    <= r_rd;
                r_wb_data  <= '0;
                r_excep    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (TIMEOUT=4). Inputs are driven and outputs
// sampled on the falling edge; the DUT updates on the rising edge.
module tb_mem_stage;

    localparam int DW = 16;

    localparam logic [4:0] OP_LD  = 5'b10001;
    localparam logic [4:0] OP_ST  = 5'b10000;
    localparam logic [4:0] OP_STU = 5'b10011;
    localparam logic [4:0] OP_ADD = 5'b00101;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_checks;
    int n_pass;

    mem_stage_if #(.DW(DW)) bus ();

    mem_stage #(.DW(DW), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_ex(input logic ldst, input logic [4:0] op, input logic [DW-1:0] res,
                            input logic [DW-1:0] sdata, input logic [2:0] rd, input logic wr);
        bus.ex_valid      = 1'b1;
        bus.ex_ldst       = ldst;
        bus.ex_opcode     = op;
        bus.ex_result     = res;
        bus.ex_store_data = sdata;
        bus.ex_rd         = rd;
        bus.ex_wr         = wr;
    endtask

    task automatic idle_ex();
        bus.ex_valid = 1'b0;
        bus.ex_ldst  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_ex();
        bus.ex_opcode = '0; bus.ex_result = '0; bus.ex_store_data = '0;
        bus.ex_rd = '0; bus.ex_wr = 1'b0;
        bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
        tick(); tick();
        n_checks++; if (bus.ex_ready !== 1'b1) $display("FAIL reset_ex_ready: got %b exp 1", bus.ex_ready); else n_pass++;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %b exp 0", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b exp 0", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.mem_excep !== 1'b0) $display("FAIL reset_excep: got %b exp 0", bus.mem_excep); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h0000) $display("FAIL reset_wb_data: got %h exp 0000", bus.wb_data); else n_pass++;
        n_checks++; if (bus.mem_addr !== 16'h0000) $display("FAIL reset_mem_addr: got %h exp 0000", bus.mem_addr); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d exp 0", dbg_state); else n_pass++;
        rst = 1'b1;
    endtask

    // Four back-to-back pass-through instructions; #2 is ldst with a
    // non-memory opcode, #3 has the LD opcode but ldst=0.
    task automatic test_nonmem_stream();
        for (int i = 1; i <= 4; i++) begin
            drive_ex(i == 2, (i == 3) ? OP_LD : OP_ADD, 16'(i), 16'hFFFF, 3'(i), 1'b1);
            n_checks++; if (bus.ex_ready !== 1'b1) $display("FAIL stream_ex_ready[%0d]: got %b exp 1", i, bus.ex_ready); else n_pass++;
            tick();
            n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL stream_wb_valid[%0d]: got %b exp 1", i, bus.wb_valid); else n_pass++;
            n_checks++; if (bus.wb_data !== 16'(i)) $display("FAIL stream_wb_data[%0d]: got %h exp %h", i, bus.wb_data, 16'(i)); else n_pass++;
            n_checks++; if (bus.wb_rd !== 3'(i)) $display("FAIL stream_wb_rd[%0d]: got %0d exp %0d", i, bus.wb_rd, i); else n_pass++;
            n_checks++; if (bus.wb_wr !== 1'b1) $display("FAIL stream_wb_wr[%0d]: got %b exp 1", i, bus.wb_wr); else n_pass++;
            n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL stream_no_req[%0d]: got %b exp 0", i, bus.mem_req_valid); else n_pass++;
        end
        idle_ex();
        tick();
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL stream_wb_end: got %b exp 0", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h0004) $display("FAIL stream_wb_hold: got %h exp 0004", bus.wb_data); else n_pass++;
    endtask

    task automatic test_load();
        bus.mem_req_ready = 1'b1;
        drive_ex(1'b1, OP_LD, 16'h1234, 16'h0000, 3'd5, 1'b1);
        tick();                                   // cycle 1: REQ
        idle_ex();
        n_checks++; if (bus.ex_ready !== 1'b0) $display("FAIL load_ready_c1: got %b exp 0", bus.ex_ready); else n_pass++;
        n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL load_req_valid: got %b exp 1", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.mem_addr !== 16'h1234) $display("FAIL load_addr: got %h exp 1234", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.mem_we !== 1'b0) $display("FAIL load_we: got %b exp 0", bus.mem_we); else n_pass++;
        // a response coinciding with request acceptance must be ignored
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'hDEAD;
        tick();                                   // cycle 2: WAIT
        n_checks++; if (bus.ex_ready !== 1'b0) $display("FAIL load_ready_c2: got %b exp 0", bus.ex_ready); else n_pass++;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL load_req_drop: got %b exp 0", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL load_wb_early: got %b exp 0", bus.wb_valid); else n_pass++;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'hBEEF;
        tick();                                   // cycle 3: writeback
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL load_wb_valid: got %b exp 1", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_wr !== 1'b1) $display("FAIL load_wb_wr: got %b exp 1", bus.wb_wr); else n_pass++;
        n_checks++; if (bus.wb_rd !== 3'd5) $display("FAIL load_wb_rd: got %0d exp 5", bus.wb_rd); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'hBEEF) $display("FAIL load_wb_data: got %h exp BEEF", bus.wb_data); else n_pass++;
        n_checks++; if (bus.ex_ready !== 1'b1) $display("FAIL load_ready_c3: got %b exp 1", bus.ex_ready); else n_pass++;
        tick();
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL load_wb_pulse: got %b exp 0", bus.wb_valid); else n_pass++;
    endtask

    task automatic test_stall_store();
        bus.mem_req_ready = 1'b0;
        drive_ex(1'b1, OP_ST, 16'h0040, 16'h00AA, 3'd6, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            idle_ex();
            n_checks++; if (bus.mem_req_valid !== 1'b1) $display("FAIL stall_req_valid[%0d]: got %b exp 1", k, bus.mem_req_valid); else n_pass++;
            n_checks++; if (bus.mem_addr !== 16'h0040) $display("FAIL stall_addr[%0d]: got %h exp 0040", k, bus.mem_addr); else n_pass++;
            n_checks++; if (bus.mem_wdata !== 16'h00AA) $display("FAIL stall_wdata[%0d]: got %h exp 00AA", k, bus.mem_wdata); else n_pass++;
            n_checks++; if (bus.mem_we !== 1'b1) $display("FAIL stall_we[%0d]: got %b exp 1", k, bus.mem_we); else n_pass++;
            n_checks++; if (bus.ex_ready !== 1'b0) $display("FAIL stall_ex_ready[%0d]: got %b exp 0", k, bus.ex_ready); else n_pass++;
        end
        bus.mem_req_ready = 1'b1;
        tick();                                   // WAIT
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL stall_req_drop: got %b exp 0", bus.mem_req_valid); else n_pass++;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'h3333;
        tick();
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL st_wb_valid: got %b exp 1", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_wr !== 1'b0) $display("FAIL st_wb_wr: got %b exp 0", bus.wb_wr); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h0000) $display("FAIL st_wb_data: got %h exp 0000", bus.wb_data); else n_pass++;
        n_checks++; if (bus.mem_excep !== 1'b0) $display("FAIL st_excep: got %b exp 0", bus.mem_excep); else n_pass++;
    endtask

    task automatic test_stu();
        bus.mem_req_ready = 1'b1;
        drive_ex(1'b1, OP_STU, 16'h0100, 16'h5555, 3'd2, 1'b1);
        tick();
        idle_ex();
        n_checks++; if (bus.mem_we !== 1'b1) $display("FAIL stu_we: got %b exp 1", bus.mem_we); else n_pass++;
        n_checks++; if (bus.mem_addr !== 16'h0100) $display("FAIL stu_addr: got %h exp 0100", bus.mem_addr); else n_pass++;
        n_checks++; if (bus.mem_wdata !== 16'h5555) $display("FAIL stu_wdata: got %h exp 5555", bus.mem_wdata); else n_pass++;
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'h7777;
        tick();
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL stu_wb_valid: got %b exp 1", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_wr !== 1'b1) $display("FAIL stu_wb_wr: got %b exp 1", bus.wb_wr); else n_pass++;
        n_checks++; if (bus.wb_rd !== 3'd2) $display("FAIL stu_wb_rd: got %0d exp 2", bus.wb_rd); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h0100) $display("FAIL stu_wb_data: got %h exp 0100", bus.wb_data); else n_pass++;
    endtask

    task automatic test_timeout();
        bus.mem_req_ready = 1'b1;
        drive_ex(1'b1, OP_LD, 16'h0200, 16'h0000, 3'd3, 1'b1);
        tick();                                   // REQ
        idle_ex();
        for (int k = 1; k <= 4; k++) begin
            tick();                               // WAIT cycles 1..4
            n_checks++; if (dbg_state !== 2'd2) $display("FAIL to_state[%0d]: got %0d exp 2", k, dbg_state); else n_pass++;
            n_checks++; if (bus.mem_excep !== 1'b0) $display("FAIL to_excep_early[%0d]: got %b exp 0", k, bus.mem_excep); else n_pass++;
        end
        tick();
        n_checks++; if (bus.mem_excep !== 1'b1) $display("FAIL to_excep: got %b exp 1", bus.mem_excep); else n_pass++;
        n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL to_wb_valid: got %b exp 1", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_wr !== 1'b0) $display("FAIL to_wb_wr: got %b exp 0", bus.wb_wr); else n_pass++;
        n_checks++; if (bus.ex_ready !== 1'b1) $display("FAIL to_ex_ready: got %b exp 1", bus.ex_ready); else n_pass++;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'h9999;   // late response
        tick();
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (bus.mem_excep !== 1'b0) $display("FAIL to_excep_pulse: got %b exp 0", bus.mem_excep); else n_pass++;
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL to_late_rsp: got %b exp 0", bus.wb_valid); else n_pass++;
        tick();
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL to_late_rsp2: got %b exp 0", bus.wb_valid); else n_pass++;
    endtask

    // Response arrives in the very WAIT cycle that would otherwise time out.
    task automatic test_rsp_at_timeout();
        bus.mem_req_ready = 1'b1;
        drive_ex(1'b1, OP_LD, 16'h0300, 16'h0000, 3'd4, 1'b1);
        tick();
        idle_ex();
        tick(); tick(); tick(); tick();           // WAIT cycle 4
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'h0ABC;
        tick();
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL edge_wb_valid: got %b exp 1", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h0ABC) $display("FAIL edge_wb_data: got %h exp 0ABC", bus.wb_data); else n_pass++;
        n_checks++; if (bus.wb_rd !== 3'd4) $display("FAIL edge_wb_rd: got %0d exp 4", bus.wb_rd); else n_pass++;
        n_checks++; if (bus.mem_excep !== 1'b0) $display("FAIL edge_excep: got %b exp 0", bus.mem_excep); else n_pass++;
    endtask

    task automatic test_reset_mid_and_back_to_back();
        bus.mem_req_ready = 1'b1;
        drive_ex(1'b1, OP_LD, 16'h0500, 16'h0000, 3'd6, 1'b1);
        tick();                                   // REQ
        idle_ex();
        tick();                                   // WAIT
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_checks++; if (bus.ex_ready !== 1'b1) $display("FAIL rmid_ex_ready: got %b exp 1", bus.ex_ready); else n_pass++;
        n_checks++; if (bus.mem_req_valid !== 1'b0) $display("FAIL rmid_req_valid: got %b exp 0", bus.mem_req_valid); else n_pass++;
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL rmid_wb_valid: got %b exp 0", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h0000) $display("FAIL rmid_wb_data: got %h exp 0000", bus.wb_data); else n_pass++;
        n_checks++; if (bus.mem_addr !== 16'h0000) $display("FAIL rmid_mem_addr: got %h exp 0000", bus.mem_addr); else n_pass++;
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'h4444;   // stale response
        tick();
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL rmid_stale_rsp: got %b exp 0", bus.wb_valid); else n_pass++;
        drive_ex(1'b1, OP_LD, 16'h0010, 16'h0000, 3'd7, 1'b1);
        tick();
        idle_ex();
        n_checks++; if (bus.mem_addr !== 16'h0010) $display("FAIL rmid_ld_addr: got %h exp 0010", bus.mem_addr); else n_pass++;
        tick();
        bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 16'h1234;
        tick();
        bus.mem_rsp_valid = 1'b0;
        n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL rmid_ld_wb_valid: got %b exp 1", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h1234) $display("FAIL rmid_ld_wb_data: got %h exp 1234", bus.wb_data); else n_pass++;
        n_checks++; if (bus.wb_rd !== 3'd7) $display("FAIL rmid_ld_wb_rd: got %0d exp 7", bus.wb_rd); else n_pass++;
        // pass-through accepted in the same cycle the load writes back
        drive_ex(1'b0, OP_ADD, 16'h00C3, 16'h0000, 3'd1, 1'b0);
        tick();
        idle_ex();
        n_checks++; if (bus.wb_valid !== 1'b1) $display("FAIL b2b_wb_valid: got %b exp 1", bus.wb_valid); else n_pass++;
        n_checks++; if (bus.wb_data !== 16'h00C3) $display("FAIL b2b_wb_data: got %h exp 00C3", bus.wb_data); else n_pass++;
        n_checks++; if (bus.wb_wr !== 1'b0) $display("FAIL b2b_wb_wr: got %b exp 0", bus.wb_wr); else n_pass++;
        tick();
        n_checks++; if (bus.wb_valid !== 1'b0) $display("FAIL b2b_wb_end: got %b exp 0", bus.wb_valid); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_nonmem_stream();
        test_load();
        test_stall_store();
        test_stu();
        test_timeout();
        test_rsp_at_timeout();
        test_reset_mid_and_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
